// File: rtl/pic_fetch_stack_if.sv
// Bus between the PIC fetch/stack block and its program ROM and decoder.
// Optional macro STACK_OVF_FLAG_EN adds the sticky stack error flag o_stk_err.
// The slave modport is the fetch/stack block. The master modport is the ROM and decoder side.
interface pic_fetch_stack_if;
  logic        i_stall;
  logic [8:0]  o_rom_addr;
  logic [11:0] i_rom_data;
  logic [11:0] o_ir;
  logic        o_ir_valid;
  logic        i_br_goto;
  logic        i_br_call;
  logic        i_br_ret;
  logic        i_br_skip;
  logic        i_pcl_we;
  logic [8:0]  i_k;
  logic [7:0]  i_pcl_data;
  logic [1:0]  o_stack_depth;
`ifdef STACK_OVF_FLAG_EN
  logic        o_stk_err;
`endif

  modport slave (
    input  i_stall, i_rom_data, i_br_goto, i_br_call, i_br_ret, i_br_skip,
           i_pcl_we, i_k, i_pcl_data,
    output o_rom_addr, o_ir, o_ir_valid, o_stack_depth
`ifdef STACK_OVF_FLAG_EN
    , output o_stk_err
`endif
  );

  modport master (
    output i_stall, i_rom_data, i_br_goto, i_br_call, i_br_ret, i_br_skip,
           i_pcl_we, i_k, i_pcl_data,
    input  o_rom_addr, o_ir, o_ir_valid, o_stack_depth
`ifdef STACK_OVF_FLAG_EN
    , input o_stk_err
`endif
  );
endinterface

// File: rtl/pic_fetch_stack.sv
// PIC-style fetch stage: the PC, the instruction register, and a two-entry return stack.
// Each taken redirect flushes the fetched word and inserts one NOP cycle.
// The optional macro STACK_OVF_FLAG_EN adds the sticky o_stk_err flag.
// o_stk_err reports a push at depth 2 or a pop at depth 0.
module pic_fetch_stack #(
  parameter logic [8:0] RESET_VECTOR = 9'h1FF
) (
  input logic              i_clk,
  input logic              i_rst,
  pic_fetch_stack_if.slave io_bus
);

  logic [8:0]  r_pc;
  logic [11:0] r_ir;
  logic        r_ir_valid;
  logic [8:0]  r_s0;
  logic [8:0]  r_s1;
  logic [1:0]  r_depth;

  logic        w_redirect_ok;
  logic        w_do_ret;
  logic        w_do_call;
  logic        w_do_goto;
  logic        w_do_pcl;
  logic        w_do_skip;
  logic        w_taken;
  logic [8:0]  w_pc_inc;
  logic [8:0]  w_pc_next;

  // Redirects apply only to a real instruction in ir and only when not stalled.
  // A flush NOP therefore can never redirect again.
  assign w_redirect_ok = ~io_bus.i_stall & r_ir_valid;
  assign w_do_ret      = w_redirect_ok & io_bus.i_br_ret;
  assign w_do_call     = w_redirect_ok & ~io_bus.i_br_ret & io_bus.i_br_call;
  assign w_do_goto     = w_redirect_ok & ~io_bus.i_br_ret & ~io_bus.i_br_call
                         & io_bus.i_br_goto;
  assign w_do_pcl      = w_redirect_ok & ~io_bus.i_br_ret & ~io_bus.i_br_call
                         & ~io_bus.i_br_goto & io_bus.i_pcl_we;
  assign w_do_skip     = w_redirect_ok & ~io_bus.i_br_ret & ~io_bus.i_br_call
                         & ~io_bus.i_br_goto & ~io_bus.i_pcl_we & io_bus.i_br_skip;
  assign w_taken       = w_do_ret | w_do_call | w_do_goto | w_do_pcl | w_do_skip;
  assign w_pc_inc      = r_pc + 9'd1;

  // Select the next PC. The redirect decodes are already mutually exclusive.
  // Skip and plain sequential fetch both advance by one.
  always_comb begin
    w_pc_next = w_pc_inc;
    if (w_do_ret)       w_pc_next = r_s0;
    else if (w_do_call) w_pc_next = {1'b0, io_bus.i_k[7:0]};
    else if (w_do_goto) w_pc_next = io_bus.i_k;
    else if (w_do_pcl)  w_pc_next = {1'b0, io_bus.i_pcl_data};
  end

  // Update the PC, the instruction register and the stack.
  // A push when full drops S1. A pop copies S1 down and leaves S1 in place.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_pc       <= RESET_VECTOR;
      r_ir       <= 12'h000;
      r_ir_valid <= 1'b0;
      r_s0       <= 9'h000;
      r_s1       <= 9'h000;
      r_depth    <= 2'd0;
    end else if (!io_bus.i_stall) begin
      r_pc <= w_pc_next;
      if (w_taken) begin
        r_ir       <= 12'h000;
        r_ir_valid <= 1'b0;
      end else begin
        r_ir       <= io_bus.i_rom_data;
        r_ir_valid <= 1'b1;
      end
      if (w_do_call) begin
        r_s1    <= r_s0;
        r_s0    <= r_pc;
        r_depth <= (r_depth == 2'd2) ? 2'd2 : r_depth + 2'd1;
      end else if (w_do_ret) begin
        r_s0    <= r_s1;
        r_depth <= (r_depth == 2'd0) ? 2'd0 : r_depth - 2'd1;
      end
    end
  end

`ifdef STACK_OVF_FLAG_EN
  logic r_stk_err;

  // Sticky flag for stack misuse. Only reset clears it.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_stk_err <= 1'b0;
    end else if ((w_do_call && r_depth == 2'd2) || (w_do_ret && r_depth == 2'd0)) begin
      r_stk_err <= 1'b1;
    end
  end

  assign io_bus.o_stk_err = r_stk_err;
`endif

  assign io_bus.o_rom_addr    = r_pc;
  assign io_bus.o_ir          = r_ir;
  assign io_bus.o_ir_valid    = r_ir_valid;
  assign io_bus.o_stack_depth = r_depth;

endmodule

// File: doc/pic_fetch_stack.md
PIC_FETCH_STACK -- requirements
Module: pic_fetch_stack

Interface
REQ-001 Parameter RESET_VECTOR, 9'h1FF, PC value loaded on reset.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset; sampled only on rising clk.
REQ-004 stall  input  1  high: all internal state holds.
REQ-005 rom_addr  output  9  program memory address; combinational copy of PC.
REQ-006 rom_data  input  12  program memory word at rom_addr, valid in the same cycle.
REQ-007 ir  output  12  instruction register presented to the decoder.
REQ-008 ir_valid  output  1  high: ir holds a real instruction; low: ir holds flush NOP.
REQ-009 br_goto, br_call, br_ret, br_skip, pcl_we  input  1 each  redirect requests from the decoder for the instruction in ir.
REQ-010 k  input  9  literal target field from ir.
REQ-011 pcl_data  input  8  new PCL value for writes to PCL.
REQ-012 stack_depth  output  2  number of valid stack entries, 0..2.

Function
REQ-013 Update when stall=0 and no redirect is taken: ir <= rom_data, ir_valid <= 1, PC <= PC+1 modulo 512 (9'h1FF wraps to 9'h000).
REQ-014 Redirect inputs are honoured only when stall=0 and ir_valid=1; otherwise they are ignored.
REQ-015 Priority when several redirect inputs are high: br_ret > br_call > br_goto > pcl_we > br_skip.
REQ-016 GOTO: PC <= k[8:0].
REQ-017 CALL: PC <= {1'b0, k[7:0]}, and the current PC (return address = call address + 1) is pushed.
REQ-018 RETLW: PC <= top of stack, and the stack is popped.
REQ-019 PCL write: PC <= {1'b0, pcl_data}.
REQ-020 Skip: PC <= PC+1.
REQ-021 Every taken redirect, including skip, sets ir <= 12'h000 and ir_valid <= 0 in the same edge, discarding the fetched word; each redirect therefore costs exactly one extra cycle.
REQ-022 The stack holds 2 entries, S0 (top) and S1.
REQ-023 Push: S1 <= S0, S0 <= PC, depth <= min(depth+1, 2).
REQ-024 Push when full: the old S1 is lost silently.
REQ-025 Pop: S0 <= S1, S1 is unchanged (bottom entry replicates), depth <= max(depth-1, 0).
REQ-026 Pop when empty: PC <= S0 (stale contents) and depth stays 0.
REQ-027 stall=1 at the same time as a redirect: stall wins, and the redirect is taken on the first non-stalled cycle if the decoder still holds it.

Reset
REQ-028 When rst=0 at a rising edge: PC <= RESET_VECTOR, ir <= 12'h000, ir_valid <= 0, S0 <= 0, S1 <= 0, stack_depth <= 0; reset overrides stall and all redirects.
REQ-029 Reset asserted mid-operation, including during a flush cycle, discards all pipeline and stack state within that one edge.
REQ-030 After reset is released, the first non-stalled edge loads ir from address RESET_VECTOR and PC wraps to 9'h000.

Configuration
REQ-031 With STACK_OVF_FLAG_EN defined, the module adds output stk_err (1 bit, reset 0).
REQ-032 stk_err is set sticky on a push at depth 2 or a pop at depth 0, and is cleared only by reset.
REQ-033 With STACK_OVF_FLAG_EN undefined, the stk_err port and its logic are absent, and all other behaviour is identical.

Verification
REQ-034 Reset then 3 free-running cycles with ROM word = address -> ir sequence 0x1FF, 0x000, 0x001; rom_addr sequence 0x1FF, 0x000, 0x001, 0x002; ir_valid 0,1,1,1.
REQ-035 CALL at 0x005 with k=0x040, then RETLW at 0x040 -> stack_depth 1 after CALL; one flush NOP after each instruction; execution resumes at 0x006; stack_depth returns to 0.
REQ-036 Three nested CALLs from 0x010, 0x020 and 0x030 -> depth stays 2; after two RETLWs PC = 0x031 then 0x021; third RETLW returns to 0x021 again; stk_err=1 when the macro is defined.
REQ-037 Skip at 0x00A -> word 0x00B is replaced by a NOP with ir_valid=0; next valid ir comes from 0x00C.
REQ-038 br_goto with k=0x1FE held under stall=1 for 3 cycles -> PC, ir and stack unchanged; redirect taken on the first stall=0 edge; after one NOP, fetch continues 0x1FE, 0x1FF, 0x000.
REQ-039 rst=0 asserted in the flush cycle after a CALL -> next cycle PC=0x1FF, stack_depth=0, ir_valid=0, and stk_err cleared.
